// File: rtl/multiword_carry_ctrl_if.sv
// Bus bundle between the multi-word carry controller and its user/N-bit unit.
// master drives operation control and per-word results; slave is the controller.
interface multiword_carry_ctrl_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic          start;
  logic          carry_init;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  s_in;
  logic          c_out_in;
  logic          c_in_out;
  logic [N-1:0]  res_word;
  logic          res_valid;
  logic [IW-1:0] res_index;
  logic          busy;
  logic          done;
  logic          flag_c;
  logic          flag_z;

  modport master (
    output start, carry_init, in_valid, s_in, c_out_in,
    input  in_ready, c_in_out, res_word, res_valid, res_index,
           busy, done, flag_c, flag_z
  );

  modport slave (
    input  start, carry_init, in_valid, s_in, c_out_in,
    output in_ready, c_in_out, res_word, res_valid, res_index,
           busy, done, flag_c, flag_z
  );
endinterface

// File: rtl/multiword_carry_ctrl.sv
// Sequences a WORDS-long multi-word operation through an N-bit add/AND unit,
// chaining the carry word to word and accumulating final carry/zero flags.
module multiword_carry_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multiword_carry_ctrl_if.slave bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          carry_reg, carry_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          zacc_reg, zacc_next;
  logic [N-1:0]  res_word_reg, res_word_next;
  logic [IW-1:0] res_index_reg, res_index_next;
  logic          res_valid_reg, res_valid_next;
  logic          flag_c_reg, flag_c_next;
  logic          flag_z_reg, flag_z_next;

  logic          in_ready;
  logic          busy;
  logic          done;
  logic          c_in_out;
  logic          word_zero;

  assign word_zero = (bus.s_in == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      zacc_reg      <= 1'b1;
      res_word_reg  <= '0;
      res_index_reg <= '0;
      res_valid_reg <= 1'b0;
      flag_c_reg    <= 1'b0;
      flag_z_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      carry_reg     <= carry_next;
      idx_reg       <= idx_next;
      zacc_reg      <= zacc_next;
      res_word_reg  <= res_word_next;
      res_index_reg <= res_index_next;
      res_valid_reg <= res_valid_next;
      flag_c_reg    <= flag_c_next;
      flag_z_reg    <= flag_z_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    carry_next     = carry_reg;
    idx_next       = idx_reg;
    zacc_next      = zacc_reg;
    res_word_next  = res_word_reg;
    res_index_next = res_index_reg;
    res_valid_next = 1'b0;
    flag_c_next    = flag_c_reg;
    flag_z_next    = flag_z_reg;
    in_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    c_in_out       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_RUN;
          carry_next = bus.carry_init;
          idx_next   = '0;
          zacc_next  = 1'b1;
        end
      end

      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Carry reaches the unit with no register stage so each word
        // completes in the cycle it is presented.
        c_in_out = carry_reg;
        if (bus.in_valid) begin
          res_word_next  = bus.s_in;
          res_index_next = idx_reg;
          res_valid_next = 1'b1;
          carry_next     = bus.c_out_in;
          zacc_next      = zacc_reg && word_zero;
          if (idx_reg == LAST_IDX) begin
            state_next  = ST_DONE;
            idx_next    = '0;
            flag_c_next = bus.c_out_in;
            flag_z_next = zacc_reg && word_zero;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.c_in_out  = c_in_out;
  assign bus.res_word  = res_word_reg;
  assign bus.res_index = res_index_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.flag_c    = flag_c_reg;
  assign bus.flag_z    = flag_z_reg;
endmodule

// File: tb/tb_multiword_carry_ctrl.sv
// Randomized scoreboard bench for multiword_carry_ctrl: a driver issues
// operations and queues expected results, a monitor checks each res_valid.
module tb_multiword_carry_ctrl;
  localparam int N     = 4;
  localparam int WORDS = 4;

  typedef struct {
    int word;
    int idx;
    bit last;
    bit fc;
    bit fz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // Reference state: the flags the last completed operation should leave.
  bit   model_fc;
  bit   model_fz;
  int   op_s[WORDS];
  bit   op_c[WORDS];

  multiword_carry_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_carry_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every res_valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_res_valid actual=1 required=0 word=%0d (t=%0t)",
                   bus.res_word, $time);
        end else begin
          e = exp_q.pop_front();
          $display("res idx=%0d word=%h done=%0d flag_c=%0d flag_z=%0d",
                   bus.res_index, bus.res_word, bus.done, bus.flag_c, bus.flag_z);
          chk("res_word", int'(bus.res_word), e.word);
          chk("res_index", int'(bus.res_index), e.idx);
          chk("done_with_last", int'(bus.done), int'(e.last));
          chk("flag_c", int'(bus.flag_c), int'(e.fc));
          chk("flag_z", int'(bus.flag_z), int'(e.fz));
        end
      end else if (bus.done) begin
        checks++;
        errors++;
        $display("FAIL done_without_res_valid actual=1 required=0 (t=%0t)", $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_c_in_out"}, int'(bus.c_in_out), 0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_res_word"}, int'(bus.res_word), 0);
    chk({tag, "_res_index"}, int'(bus.res_index), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_flag_c"}, int'(bus.flag_c), 0);
    chk({tag, "_flag_z"}, int'(bus.flag_z), 0);
  endtask

  task automatic random_words();
    for (int i = 0; i < WORDS; i++) begin
      op_s[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << N) - 1));
      op_c[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // One operation using op_s/op_c. abort_after < WORDS resets after that
  // many accepted words; overlap drives in_valid together with start.
  task automatic run_op(input bit ci, input int stall_max, input int stall_at,
                        input int stall_len, input int abort_after, input bit overlap);
    bit exp_carry;
    bit all_zero;
    int stalls;
    exp_carry = ci;
    all_zero  = 1'b1;
    bus.start      = 1'b1;
    bus.carry_init = ci;
    bus.in_valid   = overlap;
    bus.s_in       = N'($urandom_range(1, (1 << N) - 1));
    bus.c_out_in   = 1'($urandom_range(0, 1));
    tick();
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.carry_init = 1'($urandom_range(0, 1));
    chk("run_busy", int'(bus.busy), 1);
    chk("run_in_ready", int'(bus.in_ready), 1);
    chk("run_first_res_valid", int'(bus.res_valid), 0);
    for (int i = 0; i < WORDS; i++) begin
      if (i == abort_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_fc = 1'b0;
        model_fz = 1'b0;
        check_reset_outputs("abort");
        return;
      end
      stalls = (i == stall_at) ? stall_len : int'($urandom_range(0, stall_max));
      for (int k = 0; k < stalls; k++) begin
        bus.in_valid = 1'b0;
        bus.start    = 1'($urandom_range(0, 1));
        bus.s_in     = N'($urandom);
        tick();
        chk("stall_c_in_out", int'(bus.c_in_out), int'(exp_carry));
        chk("stall_res_valid", int'(bus.res_valid), 0);
        chk("stall_busy", int'(bus.busy), 1);
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.s_in     = N'(op_s[i]);
      bus.c_out_in = op_c[i];
      #1;
      chk("c_in_out", int'(bus.c_in_out), int'(exp_carry));
      exp_carry = op_c[i];
      all_zero  = all_zero && (op_s[i] == 0);
      if (i == WORDS - 1) begin
        model_fc = op_c[i];
        model_fz = all_zero;
      end
      exp_q.push_back('{word: op_s[i], idx: i, last: (i == WORDS - 1),
                        fc: model_fc, fz: model_fz});
      tick();
      bus.in_valid = 1'b0;
    end
    // DONE cycle: start and in_valid must both be ignored here.
    chk("done_in_ready", int'(bus.in_ready), 0);
    chk("done_pulse", int'(bus.done), 1);
    bus.in_valid = 1'b1;
    bus.start    = 1'b1;
    bus.s_in     = N'($urandom);
    tick();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_done", int'(bus.done), 0);
    chk("idle_c_in_out", int'(bus.c_in_out), 0);
    chk("idle_flag_c", int'(bus.flag_c), int'(model_fc));
    chk("idle_flag_z", int'(bus.flag_z), int'(model_fz));
  endtask

  task automatic idle_noise(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      bus.in_valid = 1'b1;
      bus.s_in     = N'($urandom);
      bus.c_out_in = 1'($urandom_range(0, 1));
      tick();
      chk("idle_noise_busy", int'(bus.busy), 0);
      chk("idle_noise_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_fc = 1'b0;
    model_fz = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.carry_init = 1'b0;
    bus.in_valid = 1'b0;
    bus.s_in = '0;
    bus.c_out_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    idle_noise(3);

    op_s = '{5, 15, 0, 3};
    op_c = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_op(1'b0, 0, -1, 0, WORDS, 1'b0);

    op_s = '{0, 0, 0, 0};
    op_c = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_op(1'b1, 0, -1, 0, WORDS, 1'b0);

    op_s = '{5, 15, 0, 3};
    op_c = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_op(1'b0, 0, 2, 3, WORDS, 1'b0);

    random_words();
    run_op(1'b1, 0, -1, 0, 2, 1'b0);

    op_s = '{0, 0, 0, 0};
    op_c = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_op(1'b0, 0, -1, 0, WORDS, 1'b0);

    random_words();
    run_op(1'b0, 1, -1, 0, WORDS, 1'b1);

    for (int n = 0; n < 25; n++) begin
      random_words();
      idle_noise(int'($urandom_range(0, 2)));
      run_op(1'($urandom_range(0, 1)), 3, -1, 0,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, WORDS - 1)) : WORDS,
             1'($urandom_range(0, 1)));
    end

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiword_carry_ctrl.md
MULTIWORD_CARRY_CTRL -- requirements
Module: multiword_carry_ctrl

Interface
REQ-001 Parameter: N, 4, word width of the attached N-bit add/AND unit.
REQ-002 Parameter: WORDS, 4, words per multi-word operation (WORDS >= 2); IW = clog2(WORDS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a new multi-word operation; sampled only in IDLE.
REQ-006 carry_init  input  1  carry into word 0, sampled with start.
REQ-007 in_valid  input  1  s_in/c_out_in hold a valid word result.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 s_in  input  N  sum/result word from the N-bit unit.
REQ-010 c_out_in  input  1  carry out of the N-bit unit for the current word.
REQ-011 c_in_out  output  1  carry driven into the N-bit unit for the current word.
REQ-012 res_word  output  N  registered copy of the last accepted word.
REQ-013 res_valid  output  1  one-cycle pulse: res_word/res_index are new.
REQ-014 res_index  output  IW  word index of res_word, 0 = least significant.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse at operation completion.
REQ-017 flag_c  output  1  final carry of the completed operation.
REQ-018 flag_z  output  1  high when every accepted word of the operation was zero.

Function
REQ-019 The block SHALL implement states IDLE, RUN, DONE.
REQ-020 IDLE: in_ready=0, busy=0, c_in_out=0; start=1 -> RUN, carry_reg<=carry_init, idx<=0, zacc<=1.
REQ-021 RUN: in_ready=1, busy=1, c_in_out=carry_reg combinationally (zero latency to the unit).
REQ-022 Word accepted when in_valid && in_ready; on accept: res_word<=s_in, res_index<=idx, res_valid<=1 next cycle, carry_reg<=c_out_in, zacc<=zacc && (s_in==0), idx<=idx+1.
REQ-023 res_valid SHALL be 0 in every cycle not directly following an accept.
REQ-024 Accept with idx==WORDS-1 -> DONE; idx SHALL NOT wrap inside RUN.
REQ-025 DONE: lasts exactly one cycle, done=1, in_ready=0, then IDLE unconditionally.
REQ-026 On entry to DONE, flag_c<=c_out_in of the last word, flag_z<=final zacc; both hold until the next start is accepted.
REQ-027 start asserted in RUN or DONE SHALL be ignored; no restart mid-operation.
REQ-028 in_valid in IDLE or DONE SHALL be ignored (no capture, no state change).
REQ-029 start and in_valid both high in IDLE: only start takes effect; word 0 is accepted no earlier than the next cycle.
REQ-030 in_valid low in RUN: all state held, c_in_out unchanged (stall of any length).
REQ-031 done and the res_valid of the last word SHALL assert in the same cycle.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, idx=0, carry_reg=0, res_word=0, res_index=0, res_valid=0, done=0, busy=0, flag_c=0, flag_z=0, zacc=1.
REQ-033 rst mid-RUN SHALL abort the operation with no done pulse; rst has priority over start and in_valid.

Verification (N=4, WORDS=4)
REQ-034 start, carry_init=0; words s/c = 5/0, F/1, 0/1, 3/0 back-to-back -> c_in_out 0,0,1,1; res_index 0..3; done with flag_c=0, flag_z=0.
REQ-035 start, carry_init=1; four words 0/1 -> c_in_out 1,1,1,1; flag_c=1, flag_z=1, done exactly one cycle.
REQ-036 Stall: in_valid low 3 cycles between words 1 and 2 -> no res_valid during stall, c_in_out held, result identical to unstalled run.
REQ-037 start pulsed during RUN and in_valid during IDLE/DONE -> no effect; idx and flags unchanged.
REQ-038 rst asserted after word 2 -> next cycle all outputs at reset values, no done; a fresh start then completes normally.
REQ-039 start+in_valid same cycle in IDLE -> that word not captured; first res_valid only after a later accept.
